// File: rtl/residual_error_monitor_if.sv
// Sample stream and snapshot read bus for residual_error_monitor.
// est_bits lanes are two's complement; rd_residual lanes are one bit wider.
interface residual_error_monitor_if #(
  parameter int numChannels = 16,
  parameter int estBitwidth = 10,
  parameter int snapDepth   = 8
);
  localparam int addrWidth = (snapDepth > 1) ? $clog2(snapDepth) : 1;

  logic [numChannels-1:0][estBitwidth-1:0] est_bits;
  logic [numChannels-1:0]                  slcd_bits;
  logic                                    valid_in;
  logic                                    rd_en;
  logic [addrWidth-1:0]                    rd_addr;
  logic                                    rd_valid;
  logic [numChannels-1:0][estBitwidth:0]   rd_residual;
  logic [numChannels-1:0]                  rd_bits;

  modport master (
    output est_bits, slcd_bits, valid_in, rd_en, rd_addr,
    input  rd_valid, rd_residual, rd_bits
  );

  modport slave (
    input  est_bits, slcd_bits, valid_in, rd_en, rd_addr,
    output rd_valid, rd_residual, rd_bits
  );
endinterface

// File: rtl/residual_error_monitor.sv
// Per-lane slicer residual monitor: counts lanes whose residual exceeds a
// threshold and captures a triggered snapshot of residual words for readback.
module residual_error_monitor #(
  parameter int numChannels = 16,
  parameter int estBitwidth = 10,
  parameter int snapDepth   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  residual_error_monitor_if.slave       bus,
  input  logic signed [estBitwidth-1:0] bit_level,
  input  logic [estBitwidth-1:0]        err_thresh,
  input  logic                          arm,
  input  logic                          clear_count,
  output logic [31:0]                   err_count,
  output logic [1:0]                    state,
  output logic [((numChannels > 1) ? $clog2(numChannels) : 1)-1:0] trig_lane
);
  localparam int resWidth  = estBitwidth + 1;
  localparam int laneWidth = (numChannels > 1) ? $clog2(numChannels) : 1;
  localparam int addrWidth = (snapDepth > 1) ? $clog2(snapDepth) : 1;
  localparam int memDepth  = 1 << addrWidth;
  localparam int cntWidth  = $clog2(numChannels + 1);
  localparam logic [addrWidth-1:0] lastAddr = addrWidth'(snapDepth - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } fsm_t;

  fsm_t fsm;

  logic [resWidth-1:0]                    level_ext;
  logic [resWidth-1:0]                    neg_level;
  logic [numChannels-1:0][resWidth-1:0]   residual;
  logic [numChannels-1:0][resWidth-1:0]   magnitude;
  logic [numChannels-1:0]                 flags;

  logic [numChannels-1:0][resWidth-1:0]   s1_residual;
  logic [numChannels-1:0]                 s1_bits;
  logic [numChannels-1:0]                 s1_flags;
  logic                                   s1_valid;

  logic [cntWidth-1:0]                    flag_count;
  logic [32:0]                            count_sum;
  logic [laneWidth-1:0]                   first_lane;
  logic [addrWidth-1:0]                   wr_ptr;

  logic [numChannels-1:0][resWidth-1:0]   snap_res  [memDepth];
  logic [numChannels-1:0]                 snap_bits [memDepth];

  // One extra bit keeps est - (-level) and |min| exact without saturation.
  always_comb begin
    level_ext = {bit_level[estBitwidth-1], bit_level};
    neg_level = -level_ext;
    residual  = '0;
    magnitude = '0;
    flags     = '0;
    for (int i = 0; i < numChannels; i++) begin
      residual[i]  = {bus.est_bits[i][estBitwidth-1], bus.est_bits[i]}
                     - (bus.slcd_bits[i] ? level_ext : neg_level);
      magnitude[i] = residual[i][resWidth-1] ? -residual[i] : residual[i];
      flags[i]     = magnitude[i] > {1'b0, err_thresh};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_residual <= '0;
      s1_bits     <= '0;
      s1_flags    <= '0;
      s1_valid    <= 1'b0;
    end else begin
      s1_residual <= residual;
      s1_bits     <= bus.slcd_bits;
      s1_flags    <= flags;
      s1_valid    <= bus.valid_in;
    end
  end

  always_comb begin
    flag_count = '0;
    first_lane = '0;
    for (int i = 0; i < numChannels; i++) begin
      flag_count = flag_count + cntWidth'(s1_flags[i]);
    end
    for (int i = numChannels - 1; i >= 0; i--) begin
      if (s1_flags[i]) first_lane = laneWidth'(i);
    end
    count_sum = {1'b0, err_count} + 33'(flag_count);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (clear_count) begin
      err_count <= '0;
    end else if (s1_valid) begin
      err_count <= count_sum[32] ? '1 : count_sum[31:0];
    end
  end

  // Trigger word lands in entry 0; later valid words fill the rest in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      trig_lane <= '0;
      wr_ptr    <= '0;
      for (int k = 0; k < memDepth; k++) begin
        snap_res[k]  <= '0;
        snap_bits[k] <= '0;
      end
    end else begin
      case (fsm)
        IDLE: begin
          if (arm) fsm <= ARMED;
        end
        ARMED: begin
          if (s1_valid && (|s1_flags)) begin
            snap_res[0]  <= s1_residual;
            snap_bits[0] <= s1_bits;
            trig_lane    <= first_lane;
            wr_ptr       <= addrWidth'(1);
            fsm          <= (snapDepth == 1) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (s1_valid) begin
            snap_res[wr_ptr]  <= s1_residual;
            snap_bits[wr_ptr] <= s1_bits;
            wr_ptr            <= addrWidth'(wr_ptr + 1'b1);
            if (wr_ptr == lastAddr) fsm <= DONE;
          end
        end
        DONE: begin
          if (arm) fsm <= ARMED;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign state = fsm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_valid    <= 1'b0;
      bus.rd_residual <= '0;
      bus.rd_bits     <= '0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_residual <= snap_res[bus.rd_addr];
        bus.rd_bits     <= snap_bits[bus.rd_addr];
      end
    end
  end
endmodule
